block_xfer_sequencer: RTL and testbench
=======================================

Name: block_xfer_sequencer

Overview:
- Multi-cycle sequencer for ARM LDM/STM block transfers. It walks a 16-bit register list and issues one word access per set bit, lowest register at the lowest address.
- The control unit hands it a started transfer and stalls (holds instr_done low) until done pulses.
- It drives the memory address, the register index and the handshake, and computes the final base writeback value.

Parameters:
ADDR_WIDTH, 32, width of base/address/writeback values
NUM_REGS, 16, register-list width; register index width is $clog2(NUM_REGS)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  launch transfer; sampled only in IDLE
abort  input  1  flush request; cancels transfer in progress
reg_list  input  NUM_REGS  register list (bit n = Rn)
base  input  ADDR_WIDTH  Rn value at start
up  input  1  U bit: 1 = increment, 0 = decrement
pre  input  1  P bit: 1 = before, 0 = after
wb  input  1  W bit: base writeback enable
load  input  1  1 = LDM, 0 = STM
base_idx  input  4  Rn number
mem_addr  output  ADDR_WIDTH  word address of current access
mem_req  output  1  access request
mem_we  output  1  write strobe (STM), valid with mem_req
mem_ready  input  1  memory completes access this cycle
reg_idx  output  4  register being transferred
reg_we  output  1  load data write to reg_idx (mem_req & mem_ready & load)
base_wb_en  output  1  write base_wb_value to Rn (one-cycle pulse)
base_wb_value  output  ADDR_WIDTH  final base value
busy  output  1  not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at posedge): state IDLE; every output 0; internal mask/addr/count cleared. Applies mid-transfer with no done or base_wb_en pulse.
- States: IDLE, XFER, FINISH.
- IDLE:
  - start=1 latches reg_list, base, up, pre, wb, load, base_idx.
  - N = popcount(reg_list).
  - Empty list: treated as {R15} with N_wb = 16 (writeback step 0x40); otherwise N_wb = N.
  - Start address: IA = base; IB = base+4; DA = base-4N+4; DB = base-4N, with N=1 for an empty list.
  - Final value: up ? base+4*N_wb : base-4*N_wb, computed at launch and held. All arithmetic is modulo 2^ADDR_WIDTH.
  - Next state XFER; busy=1 from the next cycle.
- XFER:
  - mem_req=1; mem_we=~load.
  - reg_idx = lowest set bit of the remaining mask; mem_addr = current address.
  - When mem_ready=1: clear that bit and add 4 to the address.
  - If load, reg_we=1 in the same cycle.
  - If the cleared bit was the last one, go to FINISH.
  - While mem_ready=0, hold mem_req, mem_addr and reg_idx stable.
- FINISH (1 cycle):
  - done=1; base_wb_value = final value.
  - base_wb_en = wb & ~(load & reg_list[base_idx]); a loaded base wins over writeback.
  - Next state IDLE; start is not sampled in this cycle.
- Latency:
  - Minimum start-to-done = N+1 cycles with zero-wait memory.
  - Each wait cycle adds one.
  - Back-to-back start accepted on the first IDLE cycle after done.
- abort:
  - In XFER or FINISH: next state IDLE, no done, no base_wb_en, no further reg_we.
  - An access acked in the same cycle as abort still produces that cycle's reg_we.
  - Ignored in IDLE; abort has priority over start.
- start outside IDLE is ignored.
- The address only wraps via the 4-byte increment at 2^ADDR_WIDTH; there is no error.

Test Plan:
- LDMIA base=0x1000, list=0x000B, wb=1, zero-wait -> reg_idx 0,1,3 at addr 0x1000/0x1004/0x1008, reg_we each cycle; done at cycle 4; base_wb_value=0x100C, base_wb_en=1.
- STMDB base=0x2000, list=0xC000 (R14,R15), wb=1 -> mem_we=1; addr 0x1FF8 (R14), 0x1FFC (R15); base_wb_value=0x1FF8.
- LDMIB with mem_ready low 2 cycles on the first access, base=0x100, list=0x0001 -> mem_addr=0x104 held 3 cycles; reg_we only on the ack cycle; done 1 cycle later.
- LDMIA base_idx=2, list=0x0004, wb=1 -> base_wb_en=0; STM with the same list -> base_wb_en=1, value=base+4.
- Empty list, DA, base=0x3000 -> single access R15 at 0x3000; base_wb_value=0x2FC0.
- abort during the 2nd of 4 transfers -> busy=0 next cycle, no done/base_wb_en. Separately, reset=0 mid-XFER -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/block_xfer_sequencer_if.sv
// Memory-side bus of the LDM/STM block-transfer sequencer: one word access
// per cycle plus the register-file write strobe for loaded data.
interface block_xfer_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
);
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic                        mem_req;
    logic                        mem_we;
    logic                        mem_ready;
    logic [$clog2(NUM_REGS)-1:0] reg_idx;
    logic                        reg_we;

    // Sequencer side: issues accesses, memory answers with mem_ready.
    modport master (
        output mem_addr, mem_req, mem_we, reg_idx, reg_we,
        input  mem_ready
    );

    // Memory / register-file side.
    modport slave (
        input  mem_addr, mem_req, mem_we, reg_idx, reg_we,
        output mem_ready
    );
endinterface

// File: rtl/block_xfer_sequencer.sv
// Multi-cycle sequencer for ARM LDM/STM block transfers. Walks the register
// list lowest-first, one word access per set bit, and produces the final base
// writeback value for the control unit.
module block_xfer_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_REGS-1:0]         reg_list,
    input  logic [ADDR_WIDTH-1:0]       base,
    input  logic                        up,
    input  logic                        pre,
    input  logic                        wb,
    input  logic                        load,
    input  logic [$clog2(NUM_REGS)-1:0] base_idx,
    block_xfer_sequencer_if.master      bus,
    output logic                        base_wb_en,
    output logic [ADDR_WIDTH-1:0]       base_wb_value,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [NUM_REGS-1:0]   mask_q;      // registers still to transfer
    logic [NUM_REGS-1:0]   list_q;      // original list, for the base-conflict rule
    logic [ADDR_WIDTH-1:0] addr_q;      // address of the current access
    logic [ADDR_WIDTH-1:0] final_q;     // writeback value, fixed at launch
    logic                  load_q;
    logic                  wb_q;
    logic [IDX_W-1:0]      base_idx_q;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NUM_REGS; i++)
            popcount = popcount + CNT_W'(v[i]);
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (m[i]) lowest_set = IDX_W'(i);
    endfunction

    // Launch arithmetic: an empty list transfers R15 only but still moves the
    // base by a full 16 words.
    logic                  list_empty;
    logic [CNT_W-1:0]      n_set, n_addr, n_wb;
    logic [ADDR_WIDTH-1:0] span_addr, span_wb, start_addr, final_val;
    logic [NUM_REGS-1:0]   launch_mask;
    logic                  last_bit;

    // Compute the launch address, mask and final base value from the live inputs.
    always_comb begin
        list_empty  = (reg_list == '0);
        n_set       = popcount(reg_list);
        n_addr      = list_empty ? CNT_W'(1) : n_set;
        n_wb        = list_empty ? CNT_W'(NUM_REGS) : n_set;
        launch_mask = list_empty ? {1'b1, {(NUM_REGS-1){1'b0}}} : reg_list;
        span_addr   = ADDR_WIDTH'(n_addr) << 2;
        span_wb     = ADDR_WIDTH'(n_wb) << 2;
        final_val   = up ? base + span_wb : base - span_wb;
        unique case ({up, pre})
            2'b10:   start_addr = base;                                   // IA
            2'b11:   start_addr = base + ADDR_WIDTH'(4);                  // IB
            2'b00:   start_addr = base - span_addr + ADDR_WIDTH'(4);      // DA
            default: start_addr = base - span_addr;                       // DB
        endcase
    end

    // The access in flight is the last one when clearing its bit empties the mask.
    assign last_bit = ((mask_q & (mask_q - NUM_REGS'(1))) == '0);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Transfer context: latched at launch, mask and address advance on each ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q     <= '0;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
            base_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q     <= launch_mask;
                        list_q     <= reg_list;
                        addr_q     <= start_addr;
                        final_q    <= final_val;
                        load_q     <= load;
                        wb_q       <= wb;
                        base_idx_q <= base_idx;
                    end
                end
                XFER: begin
                    if (bus.mem_ready) begin
                        mask_q <= mask_q & (mask_q - NUM_REGS'(1));
                        addr_q <= addr_q + ADDR_WIDTH'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.reg_idx  = '0;
        bus.reg_we   = 1'b0;
        done         = 1'b0;
        base_wb_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = XFER;
            end
            XFER: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = ~load_q;
                bus.mem_addr = addr_q;
                bus.reg_idx  = lowest_set(mask_q);
                // An ack coinciding with abort still commits its load data.
                bus.reg_we   = bus.mem_ready & load_q;
                if (abort)                          state_d = IDLE;
                else if (bus.mem_ready && last_bit) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                if (!abort) begin
                    done       = 1'b1;
                    // A base register that was itself loaded keeps the loaded value.
                    base_wb_en = wb_q & ~(load_q & list_q[base_idx_q]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign base_wb_value = final_q;

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// Directed bench for block_xfer_sequencer: hand-computed LDM/STM sequences
// covering addressing modes, wait states, base conflict, empty list, wrap,
// abort and mid-transfer reset.
module tb_block_xfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, up, pre, wb, load;
    logic [15:0] reg_list;
    logic [31:0] base;
    logic [3:0]  base_idx;
    logic        base_wb_en, busy, done;
    logic [31:0] base_wb_value;

    int n_checks = 0;
    int n_errors = 0;

    block_xfer_sequencer_if bus ();

    block_xfer_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .reg_list      (reg_list),
        .base          (base),
        .up            (up),
        .pre           (pre),
        .wb            (wb),
        .load          (load),
        .base_idx      (base_idx),
        .bus           (bus),
        .base_wb_en    (base_wb_en),
        .base_wb_value (base_wb_value),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a transfer and let it be accepted on the next edge.
    task automatic launch(input logic [15:0] l, input logic [31:0] b, input logic u,
                          input logic p, input logic w, input logic ld, input logic [3:0] bi);
        reg_list = l; base = b; up = u; pre = p; wb = w; load = ld; base_idx = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Check one XFER cycle, then advance.
    task automatic expect_access(input string tag, input logic [3:0] idx, input logic [31:0] addr,
                                 input logic we_mem, input logic we_reg);
        check({tag, " req"},    bus.mem_req, 1'b1);
        check({tag, " idx"},    bus.reg_idx, idx);
        check({tag, " addr"},   bus.mem_addr, addr);
        check({tag, " mem_we"}, bus.mem_we, we_mem);
        check({tag, " reg_we"}, bus.reg_we, we_reg);
        check({tag, " done"},   done, 1'b0);
        tick();
    endtask

    // Check the FINISH cycle, then advance into IDLE.
    task automatic expect_finish(input string tag, input logic wb_en, input logic [31:0] value);
        check({tag, " done"},     done, 1'b1);
        check({tag, " wb_en"},    base_wb_en, wb_en);
        check({tag, " wb_value"}, base_wb_value, value);
        check({tag, " req"},      bus.mem_req, 1'b0);
        tick();
        check({tag, " idle"},     busy, 1'b0);
        check({tag, " done off"}, done, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; up = 1'b0; pre = 1'b0;
        wb = 1'b0; load = 1'b0; reg_list = '0; base = '0; base_idx = '0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("rst busy",     busy, 1'b0);
        check("rst req",      bus.mem_req, 1'b0);
        check("rst addr",     bus.mem_addr, 32'h0);
        check("rst wb_value", base_wb_value, 32'h0);
        check("rst done",     done, 1'b0);
        reset = 1'b1;
        tick();

        // LDMIA 0x1000, {R0,R1,R3}, writeback; done on the 4th cycle after start
        launch(16'h000B, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
        check("ldmia busy", busy, 1'b1);
        expect_access("ldmia a0", 4'd0, 32'h1000, 1'b0, 1'b1);
        expect_access("ldmia a1", 4'd1, 32'h1004, 1'b0, 1'b1);
        expect_access("ldmia a2", 4'd3, 32'h1008, 1'b0, 1'b1);
        expect_finish("ldmia", 1'b1, 32'h100C);

        // STMDB 0x2000, {R14,R15}
        launch(16'hC000, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_access("stmdb a0", 4'd14, 32'h1FF8, 1'b1, 1'b0);
        expect_access("stmdb a1", 4'd15, 32'h1FFC, 1'b1, 1'b0);
        expect_finish("stmdb", 1'b1, 32'h1FF8);

        // LDMIB 0x100, {R0}, two wait cycles before the ack
        bus.mem_ready = 1'b0;
        launch(16'h0001, 32'h0100, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        expect_access("ldmib w0", 4'd0, 32'h0104, 1'b0, 1'b0);
        expect_access("ldmib w1", 4'd0, 32'h0104, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        #1;
        expect_access("ldmib ack", 4'd0, 32'h0104, 1'b0, 1'b1);
        expect_finish("ldmib", 1'b0, 32'h0104);

        // LDMIA with the base in the list: the loaded value wins over writeback.
        // start is held through FINISH; it must only be taken in the following IDLE cycle.
        launch(16'h0004, 32'h0500, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
        expect_access("ldm base", 4'd2, 32'h0500, 1'b0, 1'b1);
        load = 1'b0;
        start = 1'b1;
        expect_finish("ldm base", 1'b0, 32'h0504);
        tick();
        start = 1'b0;
        check("b2b busy", busy, 1'b1);
        expect_access("stm base", 4'd2, 32'h0500, 1'b1, 1'b0);
        expect_finish("stm base", 1'b1, 32'h0504);

        // Empty list, LDMDA 0x3000: R15 only, base moves by 0x40
        launch(16'h0000, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
        expect_access("empty a0", 4'd15, 32'h3000, 1'b0, 1'b1);
        expect_finish("empty", 1'b1, 32'h2FC0);

        // Address wraps past 2^32
        launch(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        expect_access("wrap a0", 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        expect_access("wrap a1", 4'd1, 32'h0000_0000, 1'b1, 1'b0);
        expect_finish("wrap", 1'b1, 32'h0000_0004);

        // Abort during the 2nd of 4 loads: that ack still writes, then IDLE quietly
        launch(16'h00F0, 32'h4000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        expect_access("abort a0", 4'd4, 32'h4000, 1'b0, 1'b1);
        abort = 1'b1;
        #1;
        check("abort reg_we", bus.reg_we, 1'b1);
        tick();
        abort = 1'b0;
        check("abort busy",  busy, 1'b0);
        check("abort done",  done, 1'b0);
        check("abort wb_en", base_wb_en, 1'b0);
        check("abort req",   bus.mem_req, 1'b0);
        tick();
        check("abort stays idle", busy, 1'b0);

        // Reset in the middle of a transfer
        launch(16'h0003, 32'h6000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        check("mid busy", busy, 1'b1);
        reset = 1'b0;
        tick();
        check("mrst busy",     busy, 1'b0);
        check("mrst req",      bus.mem_req, 1'b0);
        check("mrst addr",     bus.mem_addr, 32'h0);
        check("mrst idx",      bus.reg_idx, 4'd0);
        check("mrst reg_we",   bus.reg_we, 1'b0);
        check("mrst done",     done, 1'b0);
        check("mrst wb_en",    base_wb_en, 1'b0);
        check("mrst wb_value", base_wb_value, 32'h0);
        reset = 1'b1;
        tick();
        check("mrst idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
